// File: rtl/mul_bus_master_if.sv
// rtl/mul_bus_master_if.sv - CPU-side register bus between mul_bus_master and the multiplier peripheral
interface mul_bus_master_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_wr;
    logic [31:0] sdata_rd;

    modport master (output saddress, srd, swr, sdata_wr, input sdata_rd);
    modport slave  (input saddress, srd, swr, sdata_wr, output sdata_rd);
endinterface

// File: rtl/mul_bus_master.sv
// rtl/mul_bus_master.sv - bus initiator that runs one multiply job on the peripheral and reads back results
module mul_bus_master #(
    parameter int STROBE_CYC = 1,
    parameter int POLL_GAP   = 0,
    parameter int POLL_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      op_a,
    input  logic [23:0]      op_b,
    output logic             job_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      res_w,
    output logic [5:0]       res_l,
    output logic [15:0]      res_cnt,
    output logic             err_ovf,
    output logic             err_timeout,
    mul_bus_master_if.master bus
);
    localparam int PCW_RAW = $clog2(POLL_LIMIT + 1);
    localparam int PCW     = (PCW_RAW < 8) ? 8 : PCW_RAW;
    localparam int CMAX    = (STROBE_CYC > POLL_GAP) ? STROBE_CYC : POLL_GAP;
    localparam int CW      = (CMAX < 2) ? 1 : $clog2(CMAX);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_POLL, S_GAP, S_RD_W, S_RD_L, S_RD_CNT, S_DONE
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t         state, state_d;
    phase_t         phase, phase_d;
    logic [CW-1:0]  cyc_cnt, cyc_cnt_d;
    logic [PCW-1:0] poll_cnt, poll_cnt_d;
    logic [23:0]    op_a_q, op_b_q;
    logic           accept, set_ovf, set_tmo, cap_w, cap_l, cap_cnt;
    logic           is_strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            phase    <= PH_SETUP;
            cyc_cnt  <= '0;
            poll_cnt <= '0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            cyc_cnt  <= cyc_cnt_d;
            poll_cnt <= poll_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        phase_d    = phase;
        cyc_cnt_d  = cyc_cnt;
        poll_cnt_d = poll_cnt;
        accept     = 1'b0;
        set_ovf    = 1'b0;
        set_tmo    = 1'b0;
        cap_w      = 1'b0;
        cap_l      = 1'b0;
        cap_cnt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_d    = S_WR_A1;
                    phase_d    = PH_SETUP;
                    cyc_cnt_d  = '0;
                    poll_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (cyc_cnt == CW'(POLL_GAP - 1)) begin
                    state_d   = S_POLL;
                    phase_d   = PH_SETUP;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // Every remaining state is one bus access walking SETUP -> STROBE -> HOLD.
                case (phase)
                    PH_SETUP: begin
                        phase_d   = PH_STROBE;
                        cyc_cnt_d = '0;
                    end
                    PH_STROBE: begin
                        if (cyc_cnt == CW'(STROBE_CYC - 1))
                            phase_d = PH_HOLD;
                        else
                            cyc_cnt_d = cyc_cnt + 1'b1;
                    end
                    default: begin
                        phase_d   = PH_SETUP;
                        cyc_cnt_d = '0;
                        case (state)
                            S_WR_A1: state_d = S_WR_A2;
                            S_WR_A2: state_d = S_POLL;
                            S_POLL: begin
                                poll_cnt_d = poll_cnt + 1'b1;
                                if (bus.sdata_rd == 32'd0) begin
                                    state_d = S_RD_W;
                                end else if (bus.sdata_rd == 32'd1) begin
                                    if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
                                        state_d = S_DONE;
                                        set_tmo = 1'b1;
                                    end else if (POLL_GAP > 0) begin
                                        state_d = S_GAP;
                                    end
                                end else begin
                                    state_d = S_DONE;
                                    set_ovf = 1'b1;
                                end
                            end
                            S_RD_W: begin
                                state_d = S_RD_L;
                                cap_w   = 1'b1;
                            end
                            S_RD_L: begin
                                state_d = S_RD_CNT;
                                cap_l   = 1'b1;
                            end
                            S_RD_CNT: begin
                                state_d = S_DONE;
                                cap_cnt = 1'b1;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_w       <= '0;
            res_l       <= '0;
            res_cnt     <= '0;
            err_ovf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q      <= op_a;
                op_b_q      <= op_b;
                res_w       <= '0;
                res_l       <= '0;
                res_cnt     <= '0;
                err_ovf     <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (set_ovf) err_ovf     <= 1'b1;
            if (set_tmo) err_timeout <= 1'b1;
            if (cap_w)   res_w       <= bus.sdata_rd;
            if (cap_l)   res_l       <= bus.sdata_rd[5:0];
            if (cap_cnt) res_cnt     <= bus.sdata_rd[15:0];
        end
    end

    assign job_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign is_strobe = (phase == PH_STROBE);

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        bus.saddress = 16'h0000;
        bus.sdata_wr = 32'h0;
        bus.srd      = 1'b0;
        bus.swr      = 1'b0;
        case (state)
            S_WR_A1: begin
                bus.saddress = 16'h0100;
                bus.sdata_wr = {8'h00, op_a_q};
                bus.swr      = is_strobe;
            end
            S_WR_A2: begin
                bus.saddress = 16'h0108;
                bus.sdata_wr = {8'h00, op_b_q};
                bus.swr      = is_strobe;
            end
            S_POLL: begin
                bus.saddress = 16'h0120;
                bus.srd      = is_strobe;
            end
            S_GAP: bus.saddress = 16'h0120;
            S_RD_W: begin
                bus.saddress = 16'h0110;
                bus.srd      = is_strobe;
            end
            S_RD_L: begin
                bus.saddress = 16'h0118;
                bus.srd      = is_strobe;
            end
            S_RD_CNT: begin
                bus.saddress = 16'h0130;
                bus.srd      = is_strobe;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_bus_master.sv
// tb/tb_mul_bus_master.sv - scoreboard bench for mul_bus_master against a behavioural multiplier peripheral
module tb_mul_bus_master;
    localparam int SC_A = 1;
    localparam int SC_B = 3;

    typedef struct {
        int          inst;
        logic        rd;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int          inst;
        logic [31:0] w;
        logic [5:0]  l;
        logic [15:0] cnt;
        logic        ovf;
        logic        tmo;
        int          lat;
        int          t0;
    } res_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  start;
    logic [23:0] op_a [2];
    logic [23:0] op_b [2];
    wire  [1:0]  job_ready, busy, done, err_ovf, err_timeout;
    wire  [31:0] res_w [2];
    wire  [5:0]  res_l [2];
    wire  [15:0] res_cnt [2];

    wire  [15:0] b_addr [2];
    wire  [31:0] b_wd [2];
    wire  [1:0]  b_rd, b_wr;

    logic [1:0]  p_rst;
    logic [1:0]  p_stuck1;
    logic [1:0]  swr_q;
    logic [23:0] m_a [2];
    logic [31:0] m_w [2];
    logic [5:0]  m_l [2];
    logic [15:0] m_cnt [2];
    logic [31:0] m_status [2];

    acc_t exp_acc[$];
    res_t exp_res[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   slen [2] = '{0, 0};
    logic [1:0] rd_prev = 2'b00;
    logic [1:0] wr_prev = 2'b00;

    mul_bus_master_if bus0 ();
    mul_bus_master_if bus1 ();

    mul_bus_master #(.STROBE_CYC(SC_A), .POLL_GAP(2), .POLL_LIMIT(4)) dut_a (
        .clk(clk), .reset(rst[0]), .start(start[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .job_ready(job_ready[0]), .busy(busy[0]), .done(done[0]),
        .res_w(res_w[0]), .res_l(res_l[0]), .res_cnt(res_cnt[0]),
        .err_ovf(err_ovf[0]), .err_timeout(err_timeout[0]), .bus(bus0)
    );

    mul_bus_master #(.STROBE_CYC(SC_B)) dut_b (
        .clk(clk), .reset(rst[1]), .start(start[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .job_ready(job_ready[1]), .busy(busy[1]), .done(done[1]),
        .res_w(res_w[1]), .res_l(res_l[1]), .res_cnt(res_cnt[1]),
        .err_ovf(err_ovf[1]), .err_timeout(err_timeout[1]), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_mux(input logic [15:0] addr, input logic [31:0] w,
                                           input logic [5:0] l, input logic [31:0] st,
                                           input logic stuck, input logic [15:0] cnt);
        case (addr)
            16'h0110: return w;
            16'h0118: return {26'h0, l};
            16'h0120: return stuck ? 32'd1 : st;
            16'h0130: return {16'h0, cnt};
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [47:0] mul48(input logic [23:0] a, input logic [23:0] b);
        return {24'h0, a} * {24'h0, b};
    endfunction

    function automatic logic mul_ovf(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = mul48(a, b);
        return p[47:32] != 16'h0;
    endfunction

    function automatic logic [31:0] mul_lo(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = mul48(a, b);
        return p[31:0];
    endfunction

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int k = 0; k < 32; k++) c = c + {5'h0, v[k]};
        return c;
    endfunction

    assign b_addr[0] = bus0.saddress;
    assign b_wd[0]   = bus0.sdata_wr;
    assign b_rd[0]   = bus0.srd;
    assign b_wr[0]   = bus0.swr;
    assign b_addr[1] = bus1.saddress;
    assign b_wd[1]   = bus1.sdata_wr;
    assign b_rd[1]   = bus1.srd;
    assign b_wr[1]   = bus1.swr;
    assign bus0.sdata_rd = rd_mux(b_addr[0], m_w[0], m_l[0], m_status[0], p_stuck1[0], m_cnt[0]);
    assign bus1.sdata_rd = rd_mux(b_addr[1], m_w[1], m_l[1], m_status[1], p_stuck1[1], m_cnt[1]);

    // Peripheral: computes on the operand-B write; an overflow latches status 2 until its reset.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (p_rst[i]) begin
                m_a[i]      <= '0;
                m_w[i]      <= '0;
                m_l[i]      <= '0;
                m_cnt[i]    <= '0;
                m_status[i] <= '0;
                swr_q[i]    <= 1'b0;
            end else begin
                swr_q[i] <= b_wr[i];
                if (b_wr[i] && !swr_q[i]) begin
                    if (b_addr[i] == 16'h0100) begin
                        m_a[i] <= b_wd[i][23:0];
                    end else if (b_addr[i] == 16'h0108 && m_status[i] != 32'd2) begin
                        if (mul_ovf(m_a[i], b_wd[i][23:0])) begin
                            m_status[i] <= 32'd2;
                        end else begin
                            m_w[i]      <= mul_lo(m_a[i], b_wd[i][23:0]);
                            m_l[i]      <= popcnt(mul_lo(m_a[i], b_wd[i][23:0]));
                            m_cnt[i]    <= m_cnt[i] + 16'd1;
                            m_status[i] <= 32'd0;
                        end
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_acc(input int i, input logic rd, input logic [15:0] addr, input logic [31:0] data);
        acc_t e;
        e.inst = i;
        e.rd   = rd;
        e.addr = addr;
        e.data = data;
        exp_acc.push_back(e);
    endtask

    task automatic check_access(input int i);
        acc_t e;
        if (exp_acc.size() == 0) begin
            check_eq("access_unexpected", {b_rd[i], b_wr[i], b_addr[i]}, 64'h0);
            return;
        end
        e = exp_acc.pop_front();
        check_eq("access_inst", i, e.inst);
        check_eq("access_kind", b_rd[i], e.rd);
        check_eq("access_addr", b_addr[i], e.addr);
        if (!e.rd) check_eq("access_wdata", b_wd[i], e.data);
    endtask

    task automatic check_result(input int i);
        res_t e;
        if (exp_res.size() == 0) begin
            check_eq("done_unexpected", done[i], 1'b0);
            return;
        end
        e = exp_res.pop_front();
        check_eq("done_inst", i, e.inst);
        check_eq("done_latency", cyc - e.t0, e.lat);
        check_eq("busy_at_done", busy[i], 1'b1);
        check_eq("res_w", res_w[i], e.w);
        check_eq("res_l", res_l[i], e.l);
        check_eq("res_cnt", res_cnt[i], e.cnt);
        check_eq("err_ovf", err_ovf[i], e.ovf);
        check_eq("err_timeout", err_timeout[i], e.tmo);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (b_rd[i] && b_wr[i]) check_eq("strobe_overlap", {b_rd[i], b_wr[i]}, 2'b00);
            if ((b_rd[i] && !rd_prev[i]) || (b_wr[i] && !wr_prev[i])) check_access(i);
            if (b_rd[i] || b_wr[i]) begin
                slen[i] <= slen[i] + 1;
            end else if (rd_prev[i] || wr_prev[i]) begin
                check_eq("strobe_len", slen[i], (i == 0) ? SC_A : SC_B);
                slen[i] <= 0;
            end
            if (done[i]) check_result(i);
            rd_prev[i] <= b_rd[i];
            wr_prev[i] <= b_wr[i];
        end
    end

    task automatic do_job(input int i, input logic [23:0] a, input logic [23:0] b,
                          input logic [31:0] w, input logic [5:0] l, input logic [15:0] cnt,
                          input logic ovf, input logic tmo, input int lat,
                          input int npoll, input bit reads, input bit spam);
        res_t e;
        int   n;
        bit   got;
        push_acc(i, 1'b0, 16'h0100, {8'h00, a});
        push_acc(i, 1'b0, 16'h0108, {8'h00, b});
        for (int k = 0; k < npoll; k++) push_acc(i, 1'b1, 16'h0120, 32'h0);
        if (reads) begin
            push_acc(i, 1'b1, 16'h0110, 32'h0);
            push_acc(i, 1'b1, 16'h0118, 32'h0);
            push_acc(i, 1'b1, 16'h0130, 32'h0);
        end
        @(negedge clk);
        op_a[i]  = a;
        op_b[i]  = b;
        start[i] = 1'b1;
        n = 0;
        while (!job_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        op_a[i]  = ~a;
        op_b[i]  = ~b;
        e.inst = i;
        e.w    = w;
        e.l    = l;
        e.cnt  = cnt;
        e.ovf  = ovf;
        e.tmo  = tmo;
        e.lat  = lat;
        e.t0   = cyc;
        exp_res.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (spam) start[i] = (k >= 4 && k <= 9);
            if (done[i]) got = 1'b1;
        end
        start[i] = 1'b0;
        if (!got) check_eq("done_seen", got, 1'b1);
        @(negedge clk);
        check_eq("ready_after_done", job_ready[i], 1'b1);
        check_eq("done_one_cycle", done[i], 1'b0);
    endtask

    task automatic pulse_prst(input int i);
        @(negedge clk);
        p_rst[i] = 1'b1;
        @(negedge clk);
        p_rst[i] = 1'b0;
    endtask

    initial begin : main
        int act;
        bit got;
        rst      = 2'b11;
        p_rst    = 2'b11;
        p_stuck1 = 2'b00;
        start    = 2'b00;
        op_a[0] = '0; op_a[1] = '0;
        op_b[0] = '0; op_b[1] = '0;
        repeat (3) @(negedge clk);
        rst   = 2'b00;
        p_rst = 2'b00;
        @(negedge clk);
        check_eq("rst_job_ready", job_ready, 2'b11);
        check_eq("rst_busy", busy, 2'b00);
        check_eq("rst_done", done, 2'b00);
        check_eq("rst_res_w", res_w[0], 32'h0);
        check_eq("rst_res_l_cnt", {res_l[0], res_cnt[0]}, 22'h0);
        check_eq("rst_flags", {err_ovf, err_timeout}, 4'h0);
        check_eq("rst_bus", {b_addr[0], b_wd[0]}, 48'h0);
        act = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b_rd != 2'b00 || b_wr != 2'b00 || busy != 2'b00) act++;
        end
        check_eq("idle_no_strobes", act, 0);

        do_job(0, 24'd3, 24'd5, 32'd15, 6'd4, 16'd1, 1'b0, 1'b0, 18, 1, 1'b1, 1'b0);
        do_job(0, 24'h1234, 24'h10, 32'h12340, 6'd5, 16'd2, 1'b0, 1'b0, 18, 1, 1'b1, 1'b0);
        do_job(0, 24'hFFFFFF, 24'hFFFFFF, 32'h0, 6'd0, 16'd0, 1'b1, 1'b0, 9, 1, 1'b0, 1'b0);
        do_job(0, 24'd3, 24'd5, 32'h0, 6'd0, 16'd0, 1'b1, 1'b0, 9, 1, 1'b0, 1'b0);

        pulse_prst(0);
        p_stuck1[0] = 1'b1;
        do_job(0, 24'd3, 24'd5, 32'h0, 6'd0, 16'd0, 1'b0, 1'b1, 24, 4, 1'b0, 1'b0);
        p_stuck1[0] = 1'b0;
        pulse_prst(0);

        push_acc(0, 1'b0, 16'h0100, 32'd2);
        @(negedge clk);
        op_a[0]  = 24'd2;
        op_b[0]  = 24'd2;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (b_wr[0] && b_addr[0] == 16'h0108) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("abort_reached_wr_a2", got, 1'b1);
        rst[0] = 1'b1;
        #1;
        check_eq("abort_swr_drop", b_wr[0], 1'b0);
        check_eq("abort_busy_drop", busy[0], 1'b0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        check_eq("abort_job_ready", job_ready[0], 1'b1);
        pulse_prst(0);
        do_job(0, 24'd2, 24'd2, 32'd4, 6'd1, 16'd1, 1'b0, 1'b0, 18, 1, 1'b1, 1'b0);

        do_job(1, 24'd3, 24'd5, 32'd15, 6'd4, 16'd1, 1'b0, 1'b0, 30, 1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("no_extra_job", busy[1], 1'b0);

        check_eq("acc_queue_empty", exp_acc.size(), 0);
        check_eq("res_queue_empty", exp_res.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
